shift32: RTL and testbench

SHIFT32 -- requirements
Module: shift32

---
 rtl/shift32_pkg.sv | 19 +
 rtl/shift32_stage.sv | 22 ++
 rtl/shift32.sv | 59 +++++
 tb/tb_shift32.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/shift32_pkg.sv
// shift32_pkg: shared widths, direction encodings and the bit-reverse helper
// used to run right shifts through the left-shift datapath.
package shift32_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Mirror a data word end-for-end (bit i <-> bit DATA_W-1-i).
  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) r[i] = x[DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/shift32_stage.sv
// shift32_stage: one conditional left shift by 2^K. The vacated low bits
// are zero-filled, or filled with the bits shifted out of the top when rot
// is set (rotate). Purely combinational.
module shift32_stage
  import shift32_pkg::*;
#(
  parameter int K = 0
) (
  input  logic [DATA_W-1:0] din,
  input  logic              en,
  input  logic              rot,
  output logic [DATA_W-1:0] dout
);

  localparam int SH = 1 << K;

  logic [SH-1:0] fill;

  assign fill = rot ? din[DATA_W-1 -: SH] : '0;
  assign dout = en ? {din[DATA_W-1-SH:0], fill} : din;

endmodule

// File: rtl/shift32.sv
// shift32: 32-bit logarithmic barrel shifter with a single output register.
// Left shifts go straight through five shift32_stage instances (1,2,4,8,16);
// right shifts mirror D on the way in and the result on the way out so the
// same left datapath serves both directions.
// Optional: define SHIFT32_ROTATE_EN to add the ROT input (rotate instead
// of zero fill). Without it every shift zero-fills.
module shift32
  import shift32_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [DATA_W-1:0]  D,
  input  logic [SHAMT_W-1:0] S,
  input  logic               DIR,
  input  logic               VALID_IN,
`ifdef SHIFT32_ROTATE_EN
  input  logic               ROT,
`endif
  output logic [DATA_W-1:0]  Y,
  output logic               VALID_OUT
);

  logic                           rot_sel;
  logic [SHAMT_W:0][DATA_W-1:0]   chain;
  logic [DATA_W-1:0]              y_nxt;

`ifdef SHIFT32_ROTATE_EN
  assign rot_sel = ROT;
`else
  assign rot_sel = 1'b0;
`endif

  assign chain[0] = (DIR == DIR_RIGHT) ? bit_rev(D) : D;

  // Stage k shifts by 2^k when S[k] is set.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift32_stage #(.K(k)) u_stage (
      .din  (chain[k]),
      .en   (S[k]),
      .rot  (rot_sel),
      .dout (chain[k+1])
    );
  end

  assign y_nxt = (DIR == DIR_RIGHT) ? bit_rev(chain[SHAMT_W]) : chain[SHAMT_W];

  // Output register: capture on VALID_IN, otherwise hold Y; valid is a
  // one-cycle echo of VALID_IN.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Y         <= '0;
      VALID_OUT <= 1'b0;
    end else begin
      VALID_OUT <= VALID_IN;
      if (VALID_IN) Y <= y_nxt;
    end
  end

endmodule

// File: tb/tb_shift32.sv
// tb_shift32: directed table of shift vectors plus hand-written sequences
// for streaming, valid gaps, mid-stream reset and (optionally) rotate.
module tb_shift32;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] D;
  logic [4:0]  S;
  logic        DIR;
  logic        VALID_IN;
  logic [31:0] Y;
  logic        VALID_OUT;
`ifdef SHIFT32_ROTATE_EN
  logic        ROT;
`endif

  int n_vec = 0;
  int n_err = 0;

  shift32 dut (
    .CLK       (CLK),
    .RST       (RST),
    .D         (D),
    .S         (S),
    .DIR       (DIR),
    .VALID_IN  (VALID_IN),
`ifdef SHIFT32_ROTATE_EN
    .ROT       (ROT),
`endif
    .Y         (Y),
    .VALID_OUT (VALID_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        dir;
    logic [4:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one operand at the falling edge; it is accepted at the next rising edge.
  task automatic drive(input logic dir, input logic [4:0] s, input logic [31:0] d);
    @(negedge CLK);
    DIR = dir; S = s; D = d; VALID_IN = 1'b1;
  endtask

  initial begin
    // left shifts
    tbl[0]  = '{1'b0, 5'd1,  32'd32,         32'd64};
    tbl[1]  = '{1'b0, 5'd8,  32'd1,          32'd256};
    tbl[2]  = '{1'b0, 5'd2,  32'd4,          32'd16};
    tbl[3]  = '{1'b0, 5'd20, 32'd1,          32'h0010_0000};
    tbl[4]  = '{1'b0, 5'd0,  32'd7,          32'd7};
    tbl[5]  = '{1'b0, 5'd1,  32'd100,        32'd200};
    // right shifts
    tbl[6]  = '{1'b1, 5'd1,  32'd64,         32'd32};
    tbl[7]  = '{1'b1, 5'd8,  32'd100,        32'd0};
    tbl[8]  = '{1'b1, 5'd2,  32'd40,         32'd10};
    tbl[9]  = '{1'b1, 5'd20, 32'd1,          32'd0};
    tbl[10] = '{1'b1, 5'd0,  32'd7,          32'd7};
    tbl[11] = '{1'b1, 5'd1,  32'd100,        32'd50};
    // boundaries
    tbl[12] = '{1'b0, 5'd31, 32'd1,          32'h8000_0000};
    tbl[13] = '{1'b1, 5'd31, 32'h8000_0000,  32'd1};
    tbl[14] = '{1'b1, 5'd1,  32'hFFFF_FFFF,  32'h7FFF_FFFF};
    // mixed patterns
    tbl[15] = '{1'b0, 5'd16, 32'h1234_5678,  32'h5678_0000};
    tbl[16] = '{1'b1, 5'd16, 32'h1234_5678,  32'h0000_1234};
    tbl[17] = '{1'b0, 5'd4,  32'hDEAD_BEEF,  32'hEADB_EEF0};
    tbl[18] = '{1'b1, 5'd4,  32'hDEAD_BEEF,  32'h0DEA_DBEE};

    RST = 1'b0; D = '0; S = '0; DIR = 1'b0; VALID_IN = 1'b0;
`ifdef SHIFT32_ROTATE_EN
    ROT = 1'b0;
`endif

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    check("reset_y", Y, 32'h0);
    check("reset_valid", {31'b0, VALID_OUT}, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("idle_valid", {31'b0, VALID_OUT}, 32'h0);

    // single operands with an idle cycle between each
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].dir, tbl[i].s, tbl[i].d);
      @(posedge CLK); #1;
      check($sformatf("vec%0d_y", i), Y, tbl[i].exp);
      check($sformatf("vec%0d_valid", i), {31'b0, VALID_OUT}, 32'h1);
      @(negedge CLK);
      VALID_IN = 1'b0;
    end

    // six back-to-back operands, one result per cycle in order
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i+6].dir, tbl[i+6].s, tbl[i+6].d);
      @(posedge CLK); #1;
      check($sformatf("stream%0d_y", i), Y, tbl[i+6].exp);
      check($sformatf("stream%0d_valid", i), {31'b0, VALID_OUT}, 32'h1);
    end
    // gap: valid drops, Y holds the last result even though D changes
    @(negedge CLK);
    VALID_IN = 1'b0; D = 32'hFFFF_FFFF; S = 5'd3; DIR = 1'b0;
    @(posedge CLK); #1;
    check("gap_valid", {31'b0, VALID_OUT}, 32'h0);
    check("gap_hold_y", Y, 32'd50);
    drive(1'b0, 5'd3, 32'd1);
    @(posedge CLK); #1;
    check("after_gap_y", Y, 32'd8);
    check("after_gap_valid", {31'b0, VALID_OUT}, 32'h1);

    // reset mid-stream with a fresh operand waiting to be captured
    drive(1'b0, 5'd2, 32'd3);
    #2 RST = 1'b0;
    #1;
    check("async_rst_y", Y, 32'h0);
    check("async_rst_valid", {31'b0, VALID_OUT}, 32'h0);
    @(posedge CLK); #1;
    check("rst_hold_valid", {31'b0, VALID_OUT}, 32'h0);
    check("rst_hold_y", Y, 32'h0);
    @(negedge CLK);
    VALID_IN = 1'b0; RST = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
      check("post_rst_valid", {31'b0, VALID_OUT}, 32'h0);
      check("post_rst_y", Y, 32'h0);
    end
    drive(1'b0, 5'd2, 32'd3);
    @(posedge CLK); #1;
    check("post_rst_op_y", Y, 32'd12);
    check("post_rst_op_valid", {31'b0, VALID_OUT}, 32'h1);

`ifdef SHIFT32_ROTATE_EN
    drive(1'b0, 5'd4, 32'hF000_0000);
    ROT = 1'b1;
    @(posedge CLK); #1;
    check("rotl_y", Y, 32'h0000_000F);
    drive(1'b1, 5'd1, 32'd1);
    @(posedge CLK); #1;
    check("rotr_y", Y, 32'h8000_0000);
    drive(1'b1, 5'd1, 32'd1);
    ROT = 1'b0;
    @(posedge CLK); #1;
    check("rot_off_y", Y, 32'h0);
`endif

    @(negedge CLK);
    VALID_IN = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
